dcache_ctrl: RTL
================

Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate data cache. It sits between the memory-access stage of the pipeline and the word-wide backing memory. It generates `cache_data_valid`, which the hazard unit combines with `mem_read_m`/`mem_write_m` into `cache_stall`. That stall freezes every pipeline stage, so the request inputs stay stable until this block answers.

Parameters:
INDEX_BITS, 6, number of index bits; the cache has 2**INDEX_BITS lines.
OFFSET_BITS, 2, word-offset bits; LINE_WORDS = 2**OFFSET_BITS words per line.
TAG_BITS, 30-INDEX_BITS-OFFSET_BITS, derived tag width (32-bit byte address, word aligned).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
mem_read_m  in  1  load request from the memory-access stage.
mem_write_m  in  1  store request from the memory-access stage.
addr_m  in  32  byte address; bits [1:0] are ignored.
wdata_m  in  32  store data.
cache_data_valid  out  1  request satisfied in this cycle.
rdata_m  out  32  load data; meaningful only while `cache_data_valid` & `mem_read_m`.
mem_req  out  1  backing-memory word request.
mem_we  out  1  1 = write-back word, 0 = fill word.
mem_addr  out  32  word-aligned backing-memory byte address.
mem_wdata  out  32  write-back data.
mem_ack  in  1  one-cycle pulse: backing-memory transfer done; `mem_rdata` is valid in the same cycle.
mem_rdata  in  32  fill data.

Behaviour:
- Address split: offset = addr_m[OFFSET_BITS+1:2]; index = next INDEX_BITS bits; tag = remaining upper bits.
- Storage: per line a valid bit, a dirty bit, a tag, and LINE_WORDS data words. Only the valid and dirty bits are reset; the data and tag arrays are not.
- Reset (async, rst_n=0): state=IDLE; all valid and dirty bits cleared; word counter 0; `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cache_data_valid`=0, `rdata_m`=0.
- hit = valid[index] & (tag_array[index]==tag), evaluated combinationally.
- `cache_data_valid` = (state==IDLE) & hit & (`mem_read_m` | `mem_write_m`). This is combinational, so a hit has zero stall cycles.
- With no request, `cache_data_valid`=0.
- `rdata_m` = data[index][offset], combinational.
- Store hit: at the edge where `cache_data_valid` & `mem_write_m`, write `wdata_m` into the word and set dirty[index].
- If `mem_read_m` and `mem_write_m` are both 1 (illegal), the store takes priority and `rdata_m` is don't-care.
- FSM states: IDLE, WB, FILL.
  - IDLE -> WB: request, miss, valid & dirty victim. Counter=0.
  - IDLE -> FILL: request, miss, victim clean or invalid. Counter=0.
  - WB:
    - Outputs: `mem_req`=1, `mem_we`=1, `mem_addr` = {victim tag, index, counter, 2'b00}, `mem_wdata` = data[index][counter].
    - On `mem_ack`: counter+1.
    - On `mem_ack` with counter==LINE_WORDS-1: counter wraps to 0, go to FILL.
  - FILL:
    - Outputs: `mem_req`=1, `mem_we`=0, `mem_addr` = {request tag, index, counter, 2'b00}.
    - On `mem_ack`: data[index][counter] <= `mem_rdata`, counter+1.
    - On the last word: tag <= request tag, valid=1, dirty=0, go to IDLE.
    - The next cycle hits, and a pending store is then applied through the normal hit path.
- `mem_req` stays high continuously through a WB or FILL burst and is held until each `mem_ack`; `mem_addr`/`mem_wdata` stay stable while waiting.
- `mem_req` falls in the cycle after the final ack (state==IDLE).
- Any `mem_ack` arriving while in IDLE is ignored.
- Miss latency with ack every cycle:
  - clean miss: LINE_WORDS+1 stall cycles;
  - dirty miss: 2*LINE_WORDS+1 stall cycles.
- Request dropped mid-miss: the burst completes regardless and the line is installed.
- Reset mid-burst: FSM aborts to IDLE immediately and all lines are invalid. A partly filled line is never marked valid.

Test Plan:
- Cold load at 0x100, memory acks every cycle returning 0xA0..0xA3 -> fill addresses 0x100,0x104,0x108,0x10C with `mem_we`=0; `cache_data_valid`=0 for 5 cycles, then 1 with `rdata_m`=0xA0.
- Load 0x108 after that fill -> `cache_data_valid`=1 in the same cycle, `rdata_m`=0xA2, `mem_req` stays 0.
- Store 0xDEAD to 0x104 (hit), then load 0x504 (same index, different tag) -> write-back of 0x100..0x10C with word 1 = 0xDEAD, then fill 0x500..0x50C; valid after 9 stall cycles.
- Store miss to 0x2000 with clean victim -> 4-word fill, then the store is applied. A conflicting load at 0x2400 then forces a write-back that carries the stored word.
- Random 0-5 cycle `mem_ack` delays -> `mem_addr`/`mem_wdata` held stable; exactly LINE_WORDS acks consumed per burst.
- Assert rst_n=0 after 2 fill words of a miss -> `mem_req`=0 immediately; after release, a load to the same address misses and refetches all 4 words.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and a word-wide memory.
// Hits answer combinationally; misses run an optional write-back burst followed by a line fill.
module dcache_ctrl #(
   parameter int INDEX_BITS  = 6,
   parameter int OFFSET_BITS = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read_m,
   input  logic        mem_write_m,
   input  logic [31:0] addr_m,
   input  logic [31:0] wdata_m,
   output logic        cache_data_valid,
   output logic [31:0] rdata_m,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);
   localparam int TAG_BITS   = 30 - INDEX_BITS - OFFSET_BITS;
   localparam int LINES      = 1 << INDEX_BITS;
   localparam int LINE_WORDS = 1 << OFFSET_BITS;

   typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

   state_t                  state_q, state_d;
   logic [OFFSET_BITS-1:0]  cnt_q, cnt_d;
   logic [LINES-1:0]        valid_q, valid_d;
   logic [LINES-1:0]        dirty_q, dirty_d;
   logic [INDEX_BITS-1:0]   miss_index_q, miss_index_d;
   logic [TAG_BITS-1:0]     miss_tag_q, miss_tag_d;

   logic [TAG_BITS-1:0]     tag_arr  [LINES];
   logic [31:0]             data_arr [LINES][LINE_WORDS];

   logic [OFFSET_BITS-1:0]  offset;
   logic [INDEX_BITS-1:0]   index;
   logic [TAG_BITS-1:0]     req_tag;
   logic                    req;
   logic                    hit;
   logic                    store_we;
   logic                    fill_we;
   logic                    unused_byte_bits;

   assign offset           = addr_m[OFFSET_BITS+1:2];
   assign index            = addr_m[OFFSET_BITS+INDEX_BITS+1:OFFSET_BITS+2];
   assign req_tag          = addr_m[31:OFFSET_BITS+INDEX_BITS+2];
   assign unused_byte_bits = ^addr_m[1:0];

   assign req              = mem_read_m | mem_write_m;
   assign hit              = valid_q[index] & (tag_arr[index] == req_tag);
   assign cache_data_valid = (state_q == IDLE) & hit & req;
   assign rdata_m          = hit ? data_arr[index][offset] : '0;

   // The missing line's index/tag are latched so a burst finishes even if the request goes away.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      miss_index_d = miss_index_q;
      miss_tag_d   = miss_tag_q;
      store_we     = 1'b0;
      fill_we      = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      unique case (state_q)
         IDLE: begin
            if (req && hit) begin
               if (mem_write_m) begin
                  store_we       = 1'b1;
                  dirty_d[index] = 1'b1;
               end
            end else if (req) begin
               cnt_d          = '0;
               miss_index_d   = index;
               miss_tag_d     = req_tag;
               valid_d[index] = 1'b0;
               state_d        = (valid_q[index] && dirty_q[index]) ? WB : FILL;
            end
         end
         WB: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {tag_arr[miss_index_q], miss_index_q, cnt_q, 2'b00};
            mem_wdata = data_arr[miss_index_q][cnt_q];
            if (mem_ack) begin
               cnt_d = cnt_q + 1'b1;
               if (&cnt_q) state_d = FILL;
            end
         end
         FILL: begin
            mem_req  = 1'b1;
            mem_addr = {miss_tag_q, miss_index_q, cnt_q, 2'b00};
            if (mem_ack) begin
               fill_we = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               if (&cnt_q) begin
                  valid_d[miss_index_q] = 1'b1;
                  dirty_d[miss_index_q] = 1'b0;
                  state_d               = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         valid_q      <= '0;
         dirty_q      <= '0;
         miss_index_q <= '0;
         miss_tag_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         valid_q      <= valid_d;
         dirty_q      <= dirty_d;
         miss_index_q <= miss_index_d;
         miss_tag_q   <= miss_tag_d;
      end
   end

   // Tag and data arrays carry no reset; the valid bits guard them.
   always_ff @(posedge clk) begin
      if (store_we) data_arr[index][offset] <= wdata_m;
      if (fill_we) data_arr[miss_index_q][cnt_q] <= mem_rdata;
      if (fill_we && (&cnt_q)) tag_arr[miss_index_q] <= miss_tag_q;
   end
endmodule
